// File: rtl/cla_accum_sched_if.sv
// Bundle of the operand stream, shared-adder link, result port and status of cla_accum_sched.
// The slave modport is the sequencer's view; the master modport is the surrounding datapath.
interface cla_accum_sched_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] cfg_count;
    logic             op_valid;
    logic [WIDTH-1:0] op_data;
    logic             op_ready;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH:0]   adder_sum;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;
    logic             res_ready;
    logic             busy;
    logic [CNT_W-1:0] ops_left;

    modport slave (
        input  start, cfg_count, op_valid, op_data, adder_sum, res_ready,
        output op_ready, adder_a, adder_b, adder_cin, res_valid, res_data, res_ovf,
               busy, ops_left
    );

    modport master (
        output start, cfg_count, op_valid, op_data, adder_sum, res_ready,
        input  op_ready, adder_a, adder_b, adder_cin, res_valid, res_data, res_ovf,
               busy, ops_left
    );
endinterface

// File: rtl/cla_accum_sched.sv
// Time-shares one external CLA adder to sum a counted group of operands; the result
// is held on a valid/ready port until consumed.
module cla_accum_sched #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    cla_accum_sched_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] ops_left_reg;
    logic             op_ready_reg;
    logic             res_valid_reg;
    logic [WIDTH-1:0] res_data_reg;
    logic             res_ovf_reg;
    logic             busy_reg;

    logic             handshake;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;

    // op_ready_reg is set exactly while in ACCUM, so it doubles as the accept qualifier
    assign handshake = bus.op_valid & op_ready_reg;
    assign sum_next  = bus.adder_sum[WIDTH-1:0];
    assign ovf_next  = ovf_reg | bus.adder_sum[WIDTH];

    // The shared adder only sees a real operand while a group is accumulating
    assign bus.adder_a   = acc_reg;
    assign bus.adder_b   = (state_reg == ACCUM) ? bus.op_data : '0;
    assign bus.adder_cin = 1'b0;

    assign bus.op_ready  = op_ready_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_data  = res_data_reg;
    assign bus.res_ovf   = res_ovf_reg;
    assign bus.busy      = busy_reg;
    assign bus.ops_left  = ops_left_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            ops_left_reg  <= '0;
            op_ready_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_ovf_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        acc_reg  <= '0;
                        ovf_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        if (bus.cfg_count != '0) begin
                            state_reg    <= ACCUM;
                            ops_left_reg <= bus.cfg_count;
                            op_ready_reg <= 1'b1;
                        end else begin
                            // Empty group: present a zero result straight away
                            state_reg     <= DONE;
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= '0;
                            res_ovf_reg   <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (handshake) begin
                        acc_reg      <= sum_next;
                        ovf_reg      <= ovf_next;
                        ops_left_reg <= ops_left_reg - CNT_W'(1);
                        if (ops_left_reg == CNT_W'(1)) begin
                            state_reg     <= DONE;
                            op_ready_reg  <= 1'b0;
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= sum_next;
                            res_ovf_reg   <= ovf_next;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        res_data_reg  <= '0;
                        res_ovf_reg   <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    op_ready_reg  <= 1'b0;
                    res_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end
endmodule
